// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with 2-entry skid buffer and writeback decode
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int ZERO_GUARD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mem_rdata,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              state;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [DATA_W-1:0]   main_mem, main_alu;
  logic [REG_AW-1:0]   main_rd;
  logic                main_rw, main_m2r;

  logic [DATA_W-1:0]   skid_mem, skid_alu;
  logic [REG_AW-1:0]   skid_rd;
  logic                skid_rw, skid_m2r;

  logic                accept, drain, in_rw;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // RegWrite is qualified once at capture so the r0 guard costs nothing on the output path
  assign in_rw  = in_wb[1] & ((ZERO_GUARD == 0) || (in_rd != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_mem    <= '0;
      main_alu    <= '0;
      main_rd     <= '0;
      main_rw     <= 1'b0;
      main_m2r    <= 1'b0;
      skid_mem    <= '0;
      skid_alu    <= '0;
      skid_rd     <= '0;
      skid_rw     <= 1'b0;
      skid_m2r    <= 1'b0;
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_mem    <= in_mem_rdata;
            main_alu    <= in_alu_res;
            main_rd     <= in_rd;
            main_rw     <= in_rw;
            main_m2r    <= in_wb[0];
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_mem <= in_mem_rdata;
            main_alu <= in_alu_res;
            main_rd  <= in_rd;
            main_rw  <= in_rw;
            main_m2r <= in_wb[0];
          end else if (accept) begin
            skid_mem   <= in_mem_rdata;
            skid_alu   <= in_alu_res;
            skid_rd    <= in_rd;
            skid_rw    <= in_rw;
            skid_m2r   <= in_wb[0];
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_mem   <= skid_mem;
            main_alu   <= skid_alu;
            main_rd    <= skid_rd;
            main_rw    <= skid_rw;
            main_m2r   <= skid_m2r;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_mem_rdata  = main_mem;
  assign out_alu_res    = main_alu;
  assign out_rd         = main_rd;
  assign out_mem_to_reg = main_m2r;
  // Stale data may linger after a drain or flush; never let it look like a write
  assign out_reg_write  = main_rw & out_valid_q;
  assign fwd_valid      = out_reg_write;
  assign wb_data        = main_m2r ? main_mem : main_alu;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_mem_rdata = '0;
  logic [63:0] in_alu_res = '0;
  logic [5:0]  in_rd = '0;
  logic [1:0]  in_wb = '0;

  logic        in_ready, out_valid, out_reg_write, out_mem_to_reg, fwd_valid;
  logic [63:0] out_mem_rdata, out_alu_res, wb_data;
  logic [5:0]  out_rd;

  logic        n_in_ready, n_out_valid, n_reg_write, n_mem_to_reg, n_fwd_valid;
  logic [31:0] n_mem_rdata, n_alu_res, n_wb_data;
  logic [4:0]  n_rd;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(64), .REG_AW(6), .ZERO_GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_rdata(in_mem_rdata), .in_alu_res(in_alu_res), .in_rd(in_rd), .in_wb(in_wb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mem_rdata(out_mem_rdata), .out_alu_res(out_alu_res), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
    .wb_data(wb_data), .fwd_valid(fwd_valid)
  );

  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .ZERO_GUARD(0)) dut_ng (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .in_mem_rdata(in_mem_rdata[31:0]), .in_alu_res(in_alu_res[31:0]), .in_rd(in_rd[4:0]), .in_wb(in_wb),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_mem_rdata(n_mem_rdata), .out_alu_res(n_alu_res), .out_rd(n_rd),
    .out_reg_write(n_reg_write), .out_mem_to_reg(n_mem_to_reg),
    .wb_data(n_wb_data), .fwd_valid(n_fwd_valid)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] rd, input logic [63:0] mem, input logic [63:0] alu, input logic [1:0] wb);
    in_rd = rd;
    in_mem_rdata = mem;
    in_alu_res = alu;
    in_wb = wb;
  endtask

  typedef struct {
    logic [5:0]  rd;
    logic [63:0] mem;
    logic [63:0] alu;
    logic [1:0]  wb;
    logic [63:0] exp_data;
    logic        exp_rw;
    logic        exp_rw_ng;
    logic        exp_m2r;
  } vec_t;

  typedef struct {
    logic [63:0] mem;
    logic [63:0] alu;
    logic [5:0]  rd;
    logic [1:0]  wb;
  } ent_t;

  vec_t vecs[6];
  ent_t q[$];

  initial begin
    vecs[0] = '{6'd3,  64'h55,               64'h10,               2'b10, 64'h10,               1'b1, 1'b1, 1'b0};
    vecs[1] = '{6'd4,  64'hABCD,             64'h20,               2'b11, 64'hABCD,             1'b1, 1'b1, 1'b1};
    vecs[2] = '{6'd0,  64'h1234,             64'h77,               2'b10, 64'h77,               1'b0, 1'b1, 1'b0};
    vecs[3] = '{6'd7,  64'hDEAD_BEEF_0000_0001, 64'h9,             2'b01, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{6'd63, 64'h1,                64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{6'd0,  64'h42,               64'h43,               2'b11, 64'h42,               1'b0, 1'b1, 1'b1};

    // reset state
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_wb_data", wb_data, 64'h0);
    check("rst_reg_write", out_reg_write, 1'b0);
    rst_n = 1'b1;
    tick();

    // single-entry vectors through an empty stage
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].rd, vecs[i].mem, vecs[i].alu, vecs[i].wb);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      check($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp_data);
      check($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
      check($sformatf("vec%0d_reg_write", i), out_reg_write, vecs[i].exp_rw);
      check($sformatf("vec%0d_fwd", i), fwd_valid, vecs[i].exp_rw);
      check($sformatf("vec%0d_m2r", i), out_mem_to_reg, vecs[i].exp_m2r);
      check($sformatf("vec%0d_rw_noguard", i), n_reg_write, vecs[i].exp_rw_ng);
      tick();
      check($sformatf("vec%0d_drained", i), out_valid, 1'b0);
    end

    // back-to-back stream, one entry per cycle
    drive(6'd3, 64'h0, 64'h10, 2'b10);
    in_valid = 1'b1;
    tick();
    check("stream_a_data", wb_data, 64'h10);
    check("stream_a_ready", in_ready, 1'b1);
    drive(6'd4, 64'hABCD, 64'h0, 2'b11);
    tick();
    check("stream_b_data", wb_data, 64'hABCD);
    check("stream_b_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", out_valid, 1'b0);

    // backpressure fills skid, third push held off, then drains in order
    out_ready = 1'b0;
    drive(6'd10, 64'h0, 64'hA, 2'b10);
    in_valid = 1'b1;
    tick();
    check("bp_one_ready", in_ready, 1'b1);
    drive(6'd11, 64'h0, 64'hB, 2'b10);
    tick();
    check("bp_two_ready", in_ready, 1'b0);
    check("bp_two_head", wb_data, 64'hA);
    drive(6'd12, 64'h0, 64'hC, 2'b10);
    tick();
    check("bp_hold_ready", in_ready, 1'b0);
    check("bp_hold_head", wb_data, 64'hA);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_rel_b", wb_data, 64'hB);
    check("bp_rel_rd", out_rd, 6'd11);
    check("bp_rel_ready", in_ready, 1'b1);
    tick();
    check("bp_rel_empty", out_valid, 1'b0);

    // flush while full with a new entry offered
    out_ready = 1'b0;
    drive(6'd20, 64'h0, 64'h20, 2'b10);
    in_valid = 1'b1;
    tick();
    drive(6'd21, 64'h0, 64'h21, 2'b10);
    tick();
    drive(6'd22, 64'h0, 64'h22, 2'b10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    check("flush_fwd", fwd_valid, 1'b0);
    out_ready = 1'b1;
    tick();
    check("flush_stays_empty", out_valid, 1'b0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(6'd5, 64'h0, 64'h30, 2'b10);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_reg_write", out_reg_write, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // random valid/ready/flush against a queue model
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic       do_flush;
      logic       do_valid;
      logic       do_ready;
      ent_t       e;
      ent_t       h;
      logic       exp_rw;
      do_flush = ($urandom_range(0, 63) == 0);
      do_valid = ($urandom_range(0, 9) < 7);
      do_ready = ($urandom_range(0, 9) < 6);
      e.mem = {$urandom, $urandom};
      e.alu = {$urandom, $urandom};
      e.rd  = 6'($urandom_range(0, 63));
      e.wb  = 2'($urandom_range(0, 3));
      drive(e.rd, e.mem, e.alu, e.wb);
      in_valid = do_valid;
      out_ready = do_ready;
      flush = do_flush;

      check("rnd_ready", in_ready, q.size() < 2);
      check("rnd_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        h = q[0];
        exp_rw = h.wb[1] && (h.rd != 0);
        check("rnd_fields", {out_mem_rdata, out_alu_res}, {h.mem, h.alu});
        check("rnd_rd", out_rd, h.rd);
        check("rnd_wb_data", wb_data, h.wb[0] ? h.mem : h.alu);
        check("rnd_fwd", {out_reg_write, fwd_valid, out_mem_to_reg}, {exp_rw, exp_rw, h.wb[0]});
      end else begin
        check("rnd_empty_fwd", {out_reg_write, fwd_valid}, 2'b00);
      end

      tick();
      if (do_flush) begin
        q.delete();
      end else begin
        logic acc;
        acc = do_valid && (q.size() < 2);
        if (do_ready && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
